// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types and constants for the register file and its writer.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ZERO_REG   = 0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-way round-robin arbiter; combinational grant, registered pointer.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Under contention the loser becomes favoured next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (&valid) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_arbiter
// Brief  : Owns the register-file write port: zero sweep after reset, then
//          round-robin sharing between two write-back requesters.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0Valid,
    output logic                  req0Ready,
    input  logic [ADDR_WIDTH-1:0] req0Addr,
    input  logic [DATA_WIDTH-1:0] req0Data,
    input  logic                  req1Valid,
    output logic                  req1Ready,
    input  logic [ADDR_WIDTH-1:0] req1Addr,
    input  logic [DATA_WIDTH-1:0] req1Data,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  initDone
);

    localparam int     CNT_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam state_t RST_STATE = INIT_ON_RESET ? INIT : RUN;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_write_register;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_init_done;

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_sweep_last;

    // Requesters are invisible to the arbiter until the sweep is over.
    assign w_valid = (r_state == RUN) ? {req1Valid, req0Valid} : 2'b00;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid (w_valid),
        .grant (w_grant)
    );

    assign req0Ready    = w_grant[0];
    assign req1Ready    = w_grant[1];
    assign w_addr       = w_grant[1] ? req1Addr : req0Addr;
    assign w_data       = w_grant[1] ? req1Data : req0Data;
    assign w_sweep_last = (r_cnt == CNT_WIDTH'(NUM_REGS - 1));

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == INIT) && w_sweep_last) begin
            w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= RST_STATE;
            r_cnt            <= '0;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_init_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_reg_write <= 1'b0;
            if (r_state == INIT) begin
                r_reg_write      <= 1'b1;
                r_write_register <= ADDR_WIDTH'(r_cnt);
                r_write_data     <= '0;
                r_cnt            <= r_cnt + 1'b1;
            end else begin
                r_init_done <= 1'b1;
                // x0 is hardwired zero: accept the handshake, suppress the write.
                if (|w_grant) begin
                    r_reg_write      <= (w_addr != ADDR_WIDTH'(ZERO_REG));
                    r_write_register <= w_addr;
                    r_write_data     <= w_data;
                end
            end
        end
    end

    assign regWrite      = r_reg_write;
    assign writeRegister = r_write_register;
    assign writeData     = r_write_data;
    assign initDone      = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_write_arbiter
// Brief  : Scoreboard bench for regfile_write_arbiter with a fairness model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0Valid, req1Valid;
    logic          req0Ready, req1Ready;
    logic [AW-1:0] req0Addr, req1Addr;
    logic [DW-1:0] req0Data, req1Data;
    logic          regWrite;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;
    logic          initDone;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Data(req0Data),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Data(req1Data),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .initDone(initDone)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  favour = 0;      // requester that wins the next tie
    bit  exp_init = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset && regWrite === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                             writeRegister, writeData);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", writeRegister, e.addr);
                    check("wr_data", writeData, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int g;
        req0Valid = v0; req0Addr = a0; req0Data = d0;
        req1Valid = v1; req1Addr = a1; req1Data = d1;
        g = -1;
        if (v0 && !v1)      g = 0;
        else if (v1 && !v0) g = 1;
        else if (v0 && v1) begin
            g      = favour;
            favour = 1 - g;
        end
        if (g == 0 && a0 != '0) wr_q.push_back({a0, d0});
        if (g == 1 && a1 != '0) wr_q.push_back({a1, d1});
        @(negedge clk);
        check("req0Ready", req0Ready, 64'(g == 0));
        check("req1Ready", req1Ready, 64'(g == 1));
        check("initDone", initDone, 64'(exp_init));
        @(posedge clk);
        #1;
        exp_init = 1'b1;
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_regWrite", regWrite, 0);
            check("rst_initDone", initDone, 0);
            check("rst_ready", {req1Ready, req0Ready}, 0);
            @(posedge clk);
            #1;
        end
        favour   = 0;
        exp_init = 1'b0;
    endtask

    // Called just after reset release, between edges.
    task automatic init_sweep();
        for (int k = 0; k < NR; k++) wr_q.push_back({AW'(k), {DW{1'b0}}});
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            check("init_ready", {req1Ready, req0Ready}, 0);
            check("init_initDone", initDone, 0);
            check("init_regWrite", regWrite, 64'(i != 0));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        req0Valid = 1'b1; req0Addr = 5'd3; req0Data = 32'h3;
        req1Valid = 1'b1; req1Addr = 5'd4; req1Data = 32'h4;
        @(posedge clk);
        #1;
        hold_reset(3);
        reset = 1'b0;
        init_sweep();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        step(0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        step(0, 0, 0, 0, 0, 0);
        step(1, 5'd7, 32'h77, 1, 5'd9, 32'h99);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, AW'($urandom_range(0, NR - 1)), $urandom,
                 $urandom_range(0, 9) < 6, AW'($urandom_range(0, NR - 1)), $urandom);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Leave the pointer favouring req1 with a write showing, then reset mid-cycle.
        while (favour != 1) step(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
        req0Valid = 1'b1; req1Valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_regWrite", regWrite, 0);
        check("async_initDone", initDone, 0);
        check("async_ready", {req1Ready, req0Ready}, 0);
        wr_q.delete();
        @(posedge clk);
        #1;
        hold_reset(2);
        reset = 1'b0;
        init_sweep();
        step(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("queue_drained", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
